// File: rtl/rv32_mod_pc_ctrl.sv
// rv32_mod_pc_ctrl: program counter and fetch sequencer for the rv32imc
// single-stage core. It fetches one instruction, holds it for execute, then
// picks the next PC: sequential, branch target, or trap vector when the
// target is misaligned.
// Optional feature macro: RV32_PC_CTRL_C_EN enables compressed-instruction
// support (2-byte ilen, halfword target alignment). When it is undefined,
// ilen is always 4 and targets must be word aligned.
module rv32_mod_pc_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_ack,
  input  logic [31:0] fetch_rdata,
  output logic [31:0] instr,
  output logic        exec_valid,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic        trap,
  output logic [31:0] trap_epc
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        trap_q, trap_d;
  logic [31:0] trap_epc_q, trap_epc_d;

  logic [31:0] ilen;
  logic        target_misaligned;

  // Instruction length and target alignment rule for the selected ISA subset.
`ifdef RV32_PC_CTRL_C_EN
  assign ilen              = (instr_q[1:0] != 2'b11) ? 32'd2 : 32'd4;
  assign target_misaligned = branch_target[0];
`else
  assign ilen              = 32'd4;
  assign target_misaligned = |branch_target[1:0];
`endif

  // State and datapath registers; reset forces BOOT so fetch_req and
  // exec_valid drop immediately and any in-flight ack or commit is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      trap_q     <= 1'b0;
      trap_epc_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      trap_q     <= trap_d;
      trap_epc_q <= trap_epc_d;
    end
  end

  // Next-state and next-PC selection; trap is a single-cycle pulse that
  // lines up with the redirected fetch request.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    trap_d     = 1'b0;
    trap_epc_d = trap_epc_q;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (fetch_ack) begin
          instr_d = fetch_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
          state_d = FETCH;
          if (branch_taken) begin
            if (target_misaligned) begin
              pc_d       = TRAP_VECTOR;
              trap_d     = 1'b1;
              trap_epc_d = pc_q;
            end else begin
              pc_d = branch_target;
            end
          end else begin
            pc_d = pc_q + ilen;
          end
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign fetch_req  = (state_q == FETCH);
  assign fetch_addr = pc_q;
  assign exec_valid = (state_q == EXEC);
  assign instr      = instr_q;
  assign pc         = pc_q;
  assign trap       = trap_q;
  assign trap_epc   = trap_epc_q;

endmodule

// File: tb/tb_rv32_mod_pc_ctrl.sv
// Directed testbench for rv32_mod_pc_ctrl: reset, delayed ack, sequential
// and branch PC update, stall hold, misaligned-target trap, 32-bit wrap and
// asynchronous reset in FETCH and in a stalled EXEC.
module tb_rv32_mod_pc_ctrl;

  logic        clk;
  logic        rst_n;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack;
  logic [31:0] fetch_rdata;
  logic [31:0] instr;
  logic        exec_valid;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic        trap;
  logic [31:0] trap_epc;

  int total = 0;
  int bad   = 0;

  rv32_mod_pc_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .TRAP_VECTOR(32'h0000_0010)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_ack    (fetch_ack),
    .fetch_rdata  (fetch_rdata),
    .instr        (instr),
    .exec_valid   (exec_valid),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .pc           (pc),
    .trap         (trap),
    .trap_epc     (trap_epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-16s observed=%h expected=%h", tag, obs, exp);
  endtask

  // In FETCH: ack this cycle with data, land in EXEC next cycle.
  task automatic do_fetch(input logic [31:0] data, input logic [31:0] exp_pc);
    chk("fetch_req", {31'b0, fetch_req}, 32'd1);
    chk("fetch_addr", fetch_addr, exp_pc);
    fetch_ack   = 1'b1;
    fetch_rdata = data;
    tick();
    fetch_ack   = 1'b0;
    fetch_rdata = 32'hDEAD_BEEF;
    chk("exec_valid", {31'b0, exec_valid}, 32'd1);
    chk("instr", instr, data);
  endtask

  // In EXEC: commit with the given branch decision.
  task automatic do_commit(input logic bt, input logic [31:0] tgt);
    stall         = 1'b0;
    branch_taken  = bt;
    branch_target = tgt;
    tick();
    branch_taken  = 1'b0;
    branch_target = 32'h0;
  endtask

  initial begin
    rst_n         = 1'b0;
    fetch_ack     = 1'b0;
    fetch_rdata   = 32'h0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    #1;
    // Reset values
    chk("rst_pc", pc, 32'h0);
    chk("rst_fetch_req", {31'b0, fetch_req}, 32'd0);
    chk("rst_fetch_addr", fetch_addr, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_exec_valid", {31'b0, exec_valid}, 32'd0);
    chk("rst_trap", {31'b0, trap}, 32'd0);
    chk("rst_trap_epc", trap_epc, 32'h0);

    tick();
    rst_n = 1'b1;
    tick();
    // Ack delayed 3 cycles: address held for 4 FETCH cycles
    for (int i = 0; i < 3; i++) begin
      chk("wait_req", {31'b0, fetch_req}, 32'd1);
      chk("wait_addr", fetch_addr, 32'h0);
      chk("wait_exec", {31'b0, exec_valid}, 32'd0);
      tick();
    end
    do_fetch(32'h0000_0013, 32'h0);
    chk("exec_no_req", {31'b0, fetch_req}, 32'd0);

    // Jump to 0x100
    do_commit(1'b1, 32'h0000_0100);
    chk("jmp_addr", fetch_addr, 32'h100);
    chk("jmp_trap", {31'b0, trap}, 32'd0);

    // Branch inputs during FETCH are ignored
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0300;
    tick();
    branch_taken  = 1'b0;
    chk("ign_br_addr", fetch_addr, 32'h100);

    // Sequential 32-bit nop: +4
    do_fetch(32'h0000_0013, 32'h100);
    do_commit(1'b0, 32'h0);
    chk("seq4_addr", fetch_addr, 32'h104);

    // Compressed encoding
    do_fetch(32'h0000_0001, 32'h104);
    do_commit(1'b0, 32'h0);
`ifdef RV32_PC_CTRL_C_EN
    chk("seq2_addr", fetch_addr, 32'h106);
    do_fetch(32'h0000_0013, 32'h106);
`else
    chk("seq2_addr", fetch_addr, 32'h108);
    do_fetch(32'h0000_0013, 32'h108);
`endif

    // Stall with branch pending: held for 3 cycles, ack ignored in EXEC
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0200;
    fetch_ack     = 1'b1;
    fetch_rdata   = 32'h1234_5677;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_exec", {31'b0, exec_valid}, 32'd1);
      chk("stall_instr", instr, 32'h0000_0013);
`ifdef RV32_PC_CTRL_C_EN
      chk("stall_pc", pc, 32'h106);
`else
      chk("stall_pc", pc, 32'h108);
`endif
    end
    fetch_ack = 1'b0;
    do_commit(1'b1, 32'h0000_0200);
    chk("stall_redir", fetch_addr, 32'h200);

    // Go to 0x40, then branch to 0x202
    do_fetch(32'h0000_0063, 32'h200);
    do_commit(1'b1, 32'h0000_0040);
    do_fetch(32'h0000_0063, 32'h40);
    do_commit(1'b1, 32'h0000_0202);
`ifdef RV32_PC_CTRL_C_EN
    chk("c_tgt_addr", fetch_addr, 32'h202);
    chk("c_tgt_trap", {31'b0, trap}, 32'd0);
    do_fetch(32'h0000_0063, 32'h202);
    do_commit(1'b1, 32'h0000_0041);
    chk("odd_trap", {31'b0, trap}, 32'd1);
    chk("odd_epc", trap_epc, 32'h202);
    chk("odd_addr", fetch_addr, 32'h10);
`else
    chk("mis_trap", {31'b0, trap}, 32'd1);
    chk("mis_epc", trap_epc, 32'h40);
    chk("mis_addr", fetch_addr, 32'h10);
    chk("mis_req", {31'b0, fetch_req}, 32'd1);
`endif
    tick();
    chk("trap_pulse_end", {31'b0, trap}, 32'd0);
    chk("epc_hold", trap_epc, 32'h0000_0000 | trap_epc_exp());

    // Wrap: 0xFFFF_FFFC + 4 -> 0
    do_fetch(32'h0000_0013, 32'h10);
    do_commit(1'b1, 32'hFFFF_FFFC);
    chk("pre_wrap_addr", fetch_addr, 32'hFFFF_FFFC);
    do_fetch(32'h0000_0013, 32'hFFFF_FFFC);
    do_commit(1'b0, 32'h0);
    chk("wrap_addr", fetch_addr, 32'h0);

    // Reset mid-fetch with a pending ack
    do_commit(1'b1, 32'h0); // still FETCH, branch ignored
    fetch_ack   = 1'b1;
    fetch_rdata = 32'h0000_0093;
    rst_n       = 1'b0;
    #1;
    chk("rf_req", {31'b0, fetch_req}, 32'd0);
    chk("rf_epc", trap_epc, 32'h0);
    tick();
    rst_n     = 1'b1;
    fetch_ack = 1'b0;
    tick();
    chk("rf_refetch_req", {31'b0, fetch_req}, 32'd1);
    chk("rf_refetch_addr", fetch_addr, 32'h0);
    chk("rf_exec", {31'b0, exec_valid}, 32'd0);
    chk("rf_instr", instr, 32'h0);

    // Reset mid-stall: no commit
    do_fetch(32'h0000_0013, 32'h0);
    do_commit(1'b1, 32'h0000_0080);
    do_fetch(32'h0000_0013, 32'h80);
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0300;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rs_exec", {31'b0, exec_valid}, 32'd0);
    chk("rs_pc", pc, 32'h0);
    chk("rs_instr", instr, 32'h0);
    stall        = 1'b0;
    branch_taken = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rs_refetch_addr", fetch_addr, 32'h0);
    chk("rs_refetch_req", {31'b0, fetch_req}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Expected trap_epc after the misaligned-branch step for this build.
  function automatic logic [31:0] trap_epc_exp();
`ifdef RV32_PC_CTRL_C_EN
    return 32'h202;
`else
    return 32'h40;
`endif
  endfunction

endmodule
